text_ram_uart_dumper: RTL and testbench
=======================================

Name: text_ram_uart_dumper

Overview:
- Reader/transmitter counterpart to the UART-receive-to-text-RAM write path.
- On a start pulse, scans the ROWS x COLS character RAM through a second read port in row-major order.
- Serialises each cell as an 8N1 UART frame on tx, so the on-screen text buffer can be dumped back to the host terminal.
- Sits beside the VGA text reader and shares the DualPortRAM via a dedicated read port.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate; bit period DIV = CLK_HZ/BAUD (integer division, truncated).
- COLS, 32, cells per row; column address width 5.
- ROWS, 4, rows; row address width 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled each cycle, and a dump begins on the first cycle it is high while idle.
- rd_row  out  2  RAM read row address.
- rd_col  out  5  RAM read column address.
- rd_data  in  8  RAM read data; valid exactly one clk after the address changes (synchronous read).
- tx  out  1  UART serial output; idle high.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses.
- done  out  1  one-cycle pulse after the last stop bit completes.

Behaviour:
Reset values (reset low, asynchronous):
- tx=1, busy=0, done=0, rd_row=0, rd_col=0.
- FSM forced to IDLE; baud counter, bit counter and shift register all cleared.
- Reset asserted mid-frame: tx returns to 1 immediately, without completing the frame.

FSM states: IDLE, ADDR, LATCH, START, DATA, STOP, ADV, EOL (EOL exists only under CRLF_EN).
- IDLE:
  - start=1 -> ADDR with rd_row=0, rd_col=0, busy=1.
  - start=1 while busy is ignored, with no restart or queueing.
- ADDR: wait one cycle for RAM latency -> LATCH.
- LATCH:
  - shift register <= {1'b0, rd_data[6:0]}.
  - If rd_data[6:0]==0 (empty cell), load 8'h20 (space) instead.
  - -> START.
- START: tx=0 for DIV cycles -> DATA.
- DATA:
  - Send 8 bits LSB first, DIV cycles each.
  - 3-bit counter; after bit 7 -> STOP.
- STOP: tx=1 for DIV cycles -> ADV.
- ADV (address advance):
  - If rd_col < COLS-1: rd_col+1 -> ADDR.
  - Else rd_col=0:
    - with CRLF_EN -> EOL;
    - without: if rd_row < ROWS-1 then rd_row+1 -> ADDR, else finish.
- Finish:
  - done=1 for one cycle, busy=0, -> IDLE.
  - rd_row and rd_col return to 0.

Timing and arithmetic:
- Baud counter counts 0..DIV-1 and is reloaded at each bit boundary.
- Frame length is exactly 10*DIV cycles.
- Inter-frame gap is exactly 3 cycles (ADV, ADDR, LATCH); tx stays 1 during the gap.
- start held high across done: a new dump begins the cycle after returning to IDLE.

Optional Feature:
CRLF_EN
- Defined:
  - At each row end, EOL transmits 8'h0D then 8'h0A as two normal 8N1 frames.
  - Then advances the row, or finishes after the last row.
  - Dump total = ROWS*(COLS+2) = 136 frames.
- Undefined:
  - No separators; dump total = ROWS*COLS = 128 frames.
  - EOL state is absent.

Test Plan (bench uses CLK_HZ=160, BAUD=10, so DIV=16):
- Reset low mid-DATA of frame 3 -> tx=1 within the same cycle. After reset high: busy=0, rd_row=0, rd_col=0, and no further frames until a new start.
- RAM preloaded with cell(r,c) = 8'h41 + ((r*32+c) mod 26); start pulse of 1 cycle -> decoded byte stream is 'A','B',... in row-major order.
  - With CRLF_EN: 0D 0A after every 32 bytes.
  - Frame count is 128 (or 136 with CRLF_EN).
  - done pulses once, and busy falls on that same cycle.
- Cell containing 8'h00, and another containing 8'hC1 -> transmitted bytes are 8'h20 and 8'h41 respectively (bit 7 is masked).
- Single frame timing on the first byte 8'h55 -> tx is low for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16 cycles. The next start bit begins exactly 3 cycles later.
- Second start pulse issued while busy -> ignored; total frame count unchanged and done pulses only once.
- start held high continuously -> back-to-back dumps. Between the last stop bit of the final frame of one dump and the start bit of the first frame of the next, the tx-high gap is ≤5 cycles.

Source files
------------

// File: rtl/text_ram_uart_dumper.sv
// Dumps a ROWS x COLS text RAM through a synchronous read port as 8N1 UART frames, row-major.
// Define CRLF_EN to append a CR/LF frame pair after each row.
module text_ram_uart_dumper #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned BAUD   = 9600,
    parameter int unsigned COLS   = 32,
    parameter int unsigned ROWS   = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    output logic [$clog2(ROWS)-1:0]   o_rd_row,
    output logic [$clog2(COLS)-1:0]   o_rd_col,
    input  logic [7:0]                i_rd_data,
    output logic                      o_tx,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int unsigned Div   = CLK_HZ / BAUD;
    localparam int unsigned BaudW = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned ColW  = $clog2(COLS);
    localparam int unsigned RowW  = $clog2(ROWS);

    typedef enum logic [2:0] {
        StIdle, StAddr, StLatch, StStart, StData, StStop, StAdv
`ifdef CRLF_EN
        , StEol
`endif
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [RowW-1:0]   r_row, w_row_nxt;
    logic [ColW-1:0]   r_col, w_col_nxt;
    logic [BaudW-1:0]  r_baud, w_baud_nxt;
    logic [2:0]        r_bit, w_bit_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              r_done, w_done_nxt;
    logic              w_tick;
    logic              w_row_end;
`ifdef CRLF_EN
    // 0: row cells pending, 1: CR sent, 2: LF sent
    logic [1:0]        r_eol, w_eol_nxt;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_row   <= '0;
            r_col   <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
`ifdef CRLF_EN
            r_eol   <= 2'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_done  <= w_done_nxt;
`ifdef CRLF_EN
            r_eol   <= w_eol_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_baud_nxt  = '0;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        w_row_end   = 1'b0;
        w_tick      = (r_baud == BaudW'(Div - 1));
`ifdef CRLF_EN
        w_eol_nxt   = r_eol;
`endif
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StAddr;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            StAddr:  w_state_nxt = StLatch;
            StLatch: begin
                // Empty cells go out as spaces; bit 7 is never sent
                w_shift_nxt = (i_rd_data[6:0] == 7'd0) ? 8'h20 : {1'b0, i_rd_data[6:0]};
                w_state_nxt = StStart;
            end
            StStart: begin
                if (w_tick) begin
                    w_state_nxt = StData;
                    w_bit_nxt   = '0;
                end else begin
                    w_baud_nxt = r_baud + BaudW'(1);
                end
            end
            StData: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = StStop;
                    end
                end else begin
                    w_baud_nxt = r_baud + BaudW'(1);
                end
            end
            StStop: begin
                if (w_tick) begin
                    w_state_nxt = StAdv;
                end else begin
                    w_baud_nxt = r_baud + BaudW'(1);
                end
            end
            StAdv: begin
`ifdef CRLF_EN
                if (r_eol == 2'd1) begin
                    w_state_nxt = StEol;
                end else if (r_eol == 2'd2) begin
                    w_eol_nxt = 2'd0;
                    w_row_end = 1'b1;
                end else if (r_col < ColW'(COLS - 1)) begin
                    w_col_nxt   = r_col + ColW'(1);
                    w_state_nxt = StAddr;
                end else begin
                    w_col_nxt   = '0;
                    w_state_nxt = StEol;
                end
`else
                if (r_col < ColW'(COLS - 1)) begin
                    w_col_nxt   = r_col + ColW'(1);
                    w_state_nxt = StAddr;
                end else begin
                    w_col_nxt = '0;
                    w_row_end = 1'b1;
                end
`endif
                if (w_row_end) begin
                    if (r_row < RowW'(ROWS - 1)) begin
                        w_row_nxt   = r_row + RowW'(1);
                        w_state_nxt = StAddr;
                    end else begin
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = StIdle;
                    end
                end
            end
`ifdef CRLF_EN
            StEol: begin
                w_shift_nxt = (r_eol == 2'd0) ? 8'h0D : 8'h0A;
                w_eol_nxt   = (r_eol == 2'd0) ? 2'd1 : 2'd2;
                w_state_nxt = StStart;
            end
`endif
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        o_tx = 1'b1;
        if (r_state == StStart) begin
            o_tx = 1'b0;
        end else if (r_state == StData) begin
            o_tx = r_shift[0];
        end
    end

    assign o_busy   = (r_state != StIdle);
    assign o_done   = r_done;
    assign o_rd_row = r_row;
    assign o_rd_col = r_col;

endmodule

// File: tb/tb_text_ram_uart_dumper.sv
// Scoreboard bench for text_ram_uart_dumper: expected bytes queued at start, popped per decoded frame.
`timescale 1ns/1ps
module tb_text_ram_uart_dumper;

    localparam int DIV  = 16;
    localparam int COLS = 32;
    localparam int ROWS = 4;
`ifdef CRLF_EN
    localparam int FRAMES = ROWS * (COLS + 2);
`else
    localparam int FRAMES = ROWS * COLS;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] rd_row;
    logic [4:0] rd_col;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] mem [0:127];
    logic [7:0] exp_q [$];
    logic [7:0] rx_log [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int frames = 0;
    int starts = 0;
    int done_cnt = 0;
    int last_gap = 0;
    int prev_start = 0;
    bit mon_active = 1'b0;
    int mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;

    text_ram_uart_dumper #(
        .CLK_HZ(160),
        .BAUD  (10),
        .COLS  (COLS),
        .ROWS  (ROWS)
    ) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_start  (start),
        .o_rd_row (rd_row),
        .o_rd_col (rd_col),
        .i_rd_data(rd_data),
        .o_tx     (tx),
        .o_busy   (busy),
        .o_done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[{rd_row, rd_col}];

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // UART decoder: samples mid-bit on negedges and pops the scoreboard per frame
    initial forever begin
        logic [7:0] exp_b;
        @(negedge clk);
        if (!reset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt = 0;
                if (starts > 0) last_gap = cyc - prev_start - 10 * DIV;
                prev_start = cyc;
                starts++;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= 24 && mon_cnt <= 136 && (mon_cnt % 16) == 8)
                mon_byte = {tx, mon_byte[7:1]};
            if (mon_cnt == 152) begin
                mon_active = 1'b0;
                frames++;
                rx_log.push_back(mon_byte);
                checks++;
                if (tx !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_bit: frame %0d tx=%b, want 1", frames, tx);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: unexpected frame %02h, want none", mon_byte);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (mon_byte !== exp_b) begin
                        errors++;
                        $display("FAIL scoreboard: frame %0d got %02h, want %02h",
                                 frames, mon_byte, exp_b);
                    end
                end
            end
        end
        if (reset && done === 1'b1) done_cnt++;
    end

    task automatic fill_pattern();
        for (int i = 0; i < 128; i++) mem[i] = 8'(8'h41 + (i % 26));
    endtask

    task automatic push_dump();
        logic [7:0] b;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                b = {1'b0, mem[r * COLS + c][6:0]};
                if (b == 8'h00) b = 8'h20;
                exp_q.push_back(b);
            end
`ifdef CRLF_EN
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
`endif
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (frames < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (frames < n) begin
            errors++;
            $display("FAIL %s: timeout, frames=%0d want %0d", name, frames, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        if (rd_row !== 2'd0) begin errors++; $display("FAIL rst_row: got %0d want 0", rd_row); end
        if (rd_col !== 5'd0) begin errors++; $display("FAIL rst_col: got %0d want 0", rd_col); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int f0, s0, k;
        fill_pattern();
        f0 = frames;
        push_dump();
        pulse_start();
        wait_frames(f0 + 2, 600, "midrst_wait");
        k = 0;
        while (!(mon_active && mon_cnt == 50) && k < 250) begin
            @(negedge clk);
            #2;
            k++;
        end
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL midrst_bit: tx=%b want 0", tx); end
        reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: tx=%b want 1", tx); end
        repeat (2) @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (rd_row !== 2'd0) begin errors++; $display("FAIL midrst_row: got %0d want 0", rd_row); end
        if (rd_col !== 5'd0) begin errors++; $display("FAIL midrst_col: got %0d want 0", rd_col); end
        s0 = starts;
        repeat (400) @(negedge clk);
        checks++;
        if (starts != s0) begin
            errors++;
            $display("FAIL midrst_quiet: %0d frame starts after reset, want 0", starts - s0);
        end
    endtask

    task automatic test_frame_timing();
        logic [7:0] val = 8'h55;
        logic       exp_tx;
        int bad, k, n;
        fill_pattern();
        mem[0] = val;
        push_dump();
        pulse_start();
        k = 0;
        while (tx !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int p = 0; p < 10; p++) begin
            bad = 0;
            for (int j = 0; j < DIV; j++) begin
                if (p > 0 || j > 0) @(negedge clk);
                exp_tx = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : val[p-1];
                if (tx !== exp_tx) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL timing_bit%0d: %0d of 16 cycles wrong, want tx=%b",
                         p, bad, exp_tx);
            end
        end
        n = 0;
        @(negedge clk);
        while (tx === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL timing_gap: gap=%0d want 3", n); end
        do_reset();
    endtask

    task automatic test_masking();
        int f0;
        fill_pattern();
        mem[0] = 8'h00;
        mem[1] = 8'hC1;
        rx_log.delete();
        f0 = frames;
        push_dump();
        pulse_start();
        wait_frames(f0 + 2, 500, "mask_wait");
        checks += 2;
        if (rx_log.size() < 2) begin
            errors += 2;
            $display("FAIL mask_bytes: got %0d bytes, want 2", rx_log.size());
        end else begin
            if (rx_log[0] !== 8'h20) begin
                errors++;
                $display("FAIL mask_empty: got %02h want 20", rx_log[0]);
            end
            if (rx_log[1] !== 8'h41) begin
                errors++;
                $display("FAIL mask_bit7: got %02h want 41", rx_log[1]);
            end
        end
        do_reset();
    endtask

    task automatic test_full_dump();
        int f0, d0, k;
        fill_pattern();
        f0 = frames;
        d0 = done_cnt;
        push_dump();
        pulse_start();
        wait_frames(f0 + 5, 1200, "dump_wait");
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL dump_busy: got %b want 1", busy); end
        pulse_start();
        k = 0;
        while (done !== 1'b1 && k < 25000) begin
            @(negedge clk);
            k++;
        end
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL dump_done: timeout, done=%b", done); end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL dump_busy_fall: busy=%b at done, want 0", busy);
        end
        repeat (300) @(negedge clk);
        checks += 5;
        if (frames - f0 != FRAMES) begin
            errors++;
            $display("FAIL dump_count: got %0d frames want %0d", frames - f0, FRAMES);
        end
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL dump_done_cnt: got %0d want 1", done_cnt - d0);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL dump_pending: %0d bytes never sent, want 0", exp_q.size());
        end
        if (rd_row !== 2'd0) begin errors++; $display("FAIL dump_row: got %0d want 0", rd_row); end
        if (rd_col !== 5'd0) begin errors++; $display("FAIL dump_col: got %0d want 0", rd_col); end
    endtask

    task automatic test_back_to_back();
        int s0, k;
        fill_pattern();
        push_dump();
        push_dump();
        @(negedge clk);
        start = 1'b1;
        k = 0;
        while (done !== 1'b1 && k < 25000) begin
            @(negedge clk);
            k++;
        end
        s0 = starts;
        k = 0;
        while (starts == s0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (starts == s0 || last_gap > 5 || last_gap < 1) begin
            errors++;
            $display("FAIL b2b_gap: gap=%0d (new start seen=%0d), want 1..5",
                     last_gap, starts != s0);
        end
        start = 1'b0;
        wait_frames(frames + 1, 400, "b2b_first");
        do_reset();
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_frame_timing();
        test_masking();
        test_full_dump();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
